seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for the Nexys A7 8-digit 7-segment display; sits directly upstream of
//  the hex-to-segment decoder. Holds a 32-bit value (8 hex nibbles) plus per-digit enable and decimal-point

---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-segment scan controller
// with frame-aligned double-buffered loads and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_en,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic                  load_pending,
  output logic                  frame_done,
  output logic [3:0]            hex,
  output logic [N_DIGITS-1:0]   AN,
  output logic                  decimal_point
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  typedef struct packed {
    logic [VW-1:0]       val;
    logic [N_DIGITS-1:0] den;
    logic [N_DIGITS-1:0] dpen;
    logic                blz;
  } disp_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  disp_t               act_q, act_d;
  disp_t               pend_q, pend_d;
  logic                lp_q, lp_d;
  logic                fd_q, fd_d;
  logic [3:0]          hex_q, hex_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                dp_q, dp_d;

  logic                tick;
  logic                boundary;
  disp_t               in_bundle;
  logic [N_DIGITS-1:0] zero_above;
  logic [N_DIGITS-1:0] blanked;
  logic [N_DIGITS-1:0] visible;

  assign tick      = (cnt_q == CNT_LAST);
  assign boundary  = tick && (idx_q == IDX_LAST);
  assign in_bundle = '{val: value, den: digit_en,
                       dpen: dp_en, blz: blank_lz};

  // Prescaler and digit index stepping.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Double buffer: loads park in pending, swap in at frame boundary.
  always_comb begin
    act_d  = act_q;
    pend_d = pend_q;
    lp_d   = lp_q;
    fd_d   = boundary;
    if (boundary) begin
      if (load) begin
        act_d = in_bundle;
        lp_d  = 1'b0;
      end else if (lp_q) begin
        act_d = pend_q;
        lp_d  = 1'b0;
      end
    end else if (load) begin
      pend_d = in_bundle;
      lp_d   = 1'b1;
    end
  end

  // Leading-zero detection: digit i blanks when nibbles i..top are 0.
  always_comb begin
    zero_above = '0;
    zero_above[N_DIGITS-1] =
      (act_q.val[VW-1 -: 4] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] &&
                      (act_q.val[4*i +: 4] == 4'h0);
    end
    blanked    = act_q.blz ? zero_above : '0;
    blanked[0] = 1'b0;
    visible    = act_q.den & ~blanked;
  end

  // Output next-state from the current digit slot.
  always_comb begin
    hex_d        = act_q.val[4*idx_q +: 4];
    an_d         = '1;
    an_d[idx_q]  = ~visible[idx_q];
    dp_d         = ~(visible[idx_q] && act_q.dpen[idx_q]);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      lp_q   <= 1'b0;
      fd_q   <= 1'b0;
      hex_q  <= 4'h0;
      an_q   <= '1;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      lp_q   <= lp_d;
      fd_q   <= fd_d;
      hex_q  <= hex_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  assign load_pending  = lp_q;
  assign frame_done    = fd_q;
  assign hex           = hex_q;
  assign AN            = an_q;
  assign decimal_point = dp_q;

endmodule
